// File: rtl/pkt_arb_pkg.sv
// Shared packet layout and sizing helpers for the QoS round-robin ejection arbiter.
package pkt_arb_pkg;

    localparam int PKT_W    = 23;
    localparam int TYPE_MSB = 22;
    localparam int TYPE_LSB = 21;
    localparam int QOS_BIT  = 20;
    localparam int SRC_MSB  = 19;
    localparam int SRC_LSB  = 14;
    localparam int TGT_MSB  = 13;
    localparam int TGT_LSB  = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    // Index width for n channels; a single channel still needs one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < n) w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pkt_qos_rr_arb_rr_pick.sv
// Round-robin pick: first set request strictly after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N     = 7,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    always_comb begin
        int j;
        j       = 0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any     = 1'b1;
                gnt_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/pkt_qos_rr_arb.sv
// QoS-first round-robin merge of N_REQ packet channels onto one registered output.
// Optional low-QoS anti-starvation aging is enabled with `define PKT_QOS_ARB_AGING_EN.
module pkt_qos_rr_arb
    import pkt_arb_pkg::*;
#(
    parameter int N_REQ = 7,
    parameter int PKT_W = pkt_arb_pkg::PKT_W,
`ifdef PKT_QOS_ARB_AGING_EN
    parameter int AGE_LIM = 8,
`endif
    localparam int IDX_W = clog2_min1(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_vld,
    output logic [N_REQ-1:0]       req_rdy,
    input  logic [N_REQ*PKT_W-1:0] req_pkt,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [PKT_W-1:0]       out_pkt,
    output logic [IDX_W-1:0]       out_idx
);

    logic [N_REQ-1:0] hi_set;
    logic [N_REQ-1:0] lo_set;
    logic [IDX_W-1:0] ptr_hi;
    logic [IDX_W-1:0] ptr_lo;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic [IDX_W-1:0] gnt_idx;
    logic             hi_any;
    logic             lo_any;
    logic             accept;
    logic             force_lo;
    logic             sel_hi;
    logic             grant;

    always_comb begin
        hi_set = '0;
        lo_set = '0;
        for (int i = 0; i < N_REQ; i++) begin
            hi_set[i] = req_vld[i] &  req_pkt[i*PKT_W + QOS_BIT];
            lo_set[i] = req_vld[i] & ~req_pkt[i*PKT_W + QOS_BIT];
        end
    end

    rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick_hi (
        .req     (hi_set),
        .ptr     (ptr_hi),
        .gnt_idx (hi_idx),
        .any     (hi_any)
    );

    rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick_lo (
        .req     (lo_set),
        .ptr     (ptr_lo),
        .gnt_idx (lo_idx),
        .any     (lo_any)
    );

`ifdef PKT_QOS_ARB_AGING_EN
    logic [7:0] age_cnt;

    assign force_lo = (age_cnt == 8'(AGE_LIM)) && lo_any;

    // Counts hi grants that bypassed waiting lo traffic; frozen under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_cnt <= '0;
        end else if (!lo_any) begin
            age_cnt <= '0;
        end else if (grant && !sel_hi) begin
            age_cnt <= '0;
        end else if (grant && sel_hi && (age_cnt != 8'(AGE_LIM))) begin
            age_cnt <= age_cnt + 8'd1;
        end
    end
`else
    assign force_lo = 1'b0;
`endif

    assign accept  = !out_vld || out_rdy;
    assign sel_hi  = hi_any && !force_lo;
    assign grant   = !rst && accept && (hi_any || lo_any);
    assign gnt_idx = sel_hi ? hi_idx : lo_idx;

    always_comb begin
        req_rdy = '0;
        if (grant) req_rdy[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_pkt <= '0;
            out_idx <= '0;
            ptr_hi  <= IDX_W'(N_REQ - 1);
            ptr_lo  <= IDX_W'(N_REQ - 1);
        end else if (grant) begin
            out_vld <= 1'b1;
            out_pkt <= req_pkt[int'(gnt_idx)*PKT_W +: PKT_W];
            out_idx <= gnt_idx;
            if (sel_hi) ptr_hi <= gnt_idx;
            else        ptr_lo <= gnt_idx;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule
